// File: rtl/menu_input_pkg.sv
// Shared types for the menu input block:
// debounce FSM encoding and menu selection levels.
package menu_input_pkg;

  typedef enum logic [1:0] {
    DB_RELEASED     = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam logic SEL_CONTINUE = 1'b0;
  localparam logic SEL_RESTART  = 1'b1;

endpackage

// File: rtl/menu_input_debounce.sv
// One bouncy contact: 2-flop sync, stability counter, 4-state FSM.
// Ports: clk, rst_n, i_raw (async level), o_rise (1-cycle press pulse).
module menu_input_debounce
  import menu_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             w_hit;

  assign w_hit  = (r_cnt == LAST);
  assign o_rise = r_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= DB_RELEASED;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise_nxt;
    end
  end

  // The first mismatch cycle is counted on entry to a WAIT
  // state, so the flip lands on the N-th mismatching cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_rise_nxt  = 1'b0;
    unique case (r_state)
      DB_RELEASED: begin
        if (r_sync2) begin
          w_cnt_nxt   = r_cnt + ONE;
          w_state_nxt = DB_PRESS_WAIT;
        end
      end
      DB_PRESS_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = DB_RELEASED;
        end else if (w_hit) begin
          w_state_nxt = DB_PRESSED;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      DB_PRESSED: begin
        if (!r_sync2) begin
          w_cnt_nxt   = r_cnt + ONE;
          w_state_nxt = DB_RELEASE_WAIT;
        end
      end
      DB_RELEASE_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = DB_PRESSED;
        end else if (w_hit) begin
          w_state_nxt = DB_RELEASED;
        end else begin
          w_cnt_nxt = r_cnt + ONE;
        end
      end
      default: begin
        w_state_nxt = DB_RELEASED;
      end
    endcase
  end

endmodule

// File: rtl/menu_input.sv
// Joystick menu input: debounced enter pulse and menu selection.
// Ports: raw contacts, menu_active, clear_sel -> enter, value, sel_changed.
module menu_input
  import menu_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic joy_up_raw,
  input  logic joy_down_raw,
  input  logic menu_active,
  input  logic clear_sel,
  output logic enter,
  output logic value,
  output logic sel_changed
);

  logic w_btn_rise;
  logic w_up_rise;
  logic w_dn_rise;
  logic w_up_ok;
  logic w_dn_ok;
  logic w_value_nxt;
  logic r_enter;
  logic r_value;
  logic r_sel_changed;

  menu_input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_btn (
    .clk   (clock),
    .rst_n (reset_n),
    .i_raw (btn_raw),
    .o_rise(w_btn_rise)
  );

  menu_input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_up (
    .clk   (clock),
    .rst_n (reset_n),
    .i_raw (joy_up_raw),
    .o_rise(w_up_rise)
  );

  menu_input_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_dn (
    .clk   (clock),
    .rst_n (reset_n),
    .i_raw (joy_down_raw),
    .o_rise(w_dn_rise)
  );

  // Simultaneous up+down cancel; pulses outside a menu are dropped.
  assign w_up_ok = menu_active & w_up_rise & ~w_dn_rise;
  assign w_dn_ok = menu_active & w_dn_rise & ~w_up_rise;

  always_comb begin
    w_value_nxt = r_value;
    if (clear_sel) begin
      w_value_nxt = SEL_CONTINUE;
    end else if (w_up_ok) begin
      w_value_nxt = SEL_CONTINUE;
    end else if (w_dn_ok) begin
      w_value_nxt = SEL_RESTART;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_enter       <= 1'b0;
      r_value       <= SEL_CONTINUE;
      r_sel_changed <= 1'b0;
    end else begin
      r_enter       <= w_btn_rise;
      r_value       <= w_value_nxt;
      r_sel_changed <= (w_value_nxt != r_value);
    end
  end

  assign enter       = r_enter;
  assign value       = r_value;
  assign sel_changed = r_sel_changed;

endmodule

// File: tb/tb_menu_input.sv
// Bench for menu_input with a 4-cycle debounce window:
// run-length model checked every cycle plus directed literal checks.
module tb_menu_input;

  localparam int N = 4;

  logic clock        = 1'b0;
  logic reset_n      = 1'b0;
  logic btn_raw      = 1'b0;
  logic joy_up_raw   = 1'b0;
  logic joy_down_raw = 1'b0;
  logic menu_active  = 1'b0;
  logic clear_sel    = 1'b0;
  logic enter;
  logic value;
  logic sel_changed;

  int errors  = 0;
  int checks  = 0;
  int n_enter = 0;
  int n_sel   = 0;

  menu_input #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
    .joy_up_raw  (joy_up_raw),
    .joy_down_raw(joy_down_raw),
    .menu_active (menu_active),
    .clear_sel   (clear_sel),
    .enter       (enter),
    .value       (value),
    .sel_changed (sel_changed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: index 0 = button, 1 = up, 2 = down.
  // A contact flips once its last N synchronised samples
  // taken since reset all disagree with its stable level.
  logic [2:0]  m_d1     = '0;
  logic [2:0]  m_d2     = '0;
  logic [2:0]  m_stable = '0;
  logic [2:0]  m_rise   = '0;
  logic [15:0] m_hist [3];
  int          m_nsamp  = 0;
  logic        exp_enter = 1'b0;
  logic        exp_value = 1'b0;
  logic        exp_sel   = 1'b0;

  always @(posedge clock) begin : model
    logic [2:0] raw;
    logic       nv;
    logic       flip;
    raw = {joy_down_raw, joy_up_raw, btn_raw};
    if (!reset_n) begin
      m_d1      = '0;
      m_d2      = '0;
      m_stable  = '0;
      m_rise    = '0;
      m_nsamp   = 0;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      exp_enter = 1'b0;
      exp_value = 1'b0;
      exp_sel   = 1'b0;
    end else begin
      exp_enter = m_rise[0];
      nv = exp_value;
      if (clear_sel)
        nv = 1'b0;
      else if (menu_active && m_rise[1] && !m_rise[2])
        nv = 1'b0;
      else if (menu_active && m_rise[2] && !m_rise[1])
        nv = 1'b1;
      exp_sel   = (nv != exp_value);
      exp_value = nv;
      if (m_nsamp < 16) m_nsamp++;
      for (int i = 0; i < 3; i++) begin
        m_hist[i] = {m_hist[i][14:0], m_d2[i]};
        flip = (m_nsamp >= N);
        for (int j = 0; j < N; j++)
          if (m_hist[i][j] == m_stable[i]) flip = 1'b0;
        m_rise[i] = flip && !m_stable[i];
        if (flip) m_stable[i] = ~m_stable[i];
      end
      m_d2 = m_d1;
      m_d1 = raw;
    end
    #1;
    chk("enter", enter, exp_enter);
    chk("value", value, exp_value);
    chk("sel_changed", sel_changed, exp_sel);
    if (enter === 1'b1) n_enter++;
    if (sel_changed === 1'b1) n_sel++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_in(input int which, input logic v);
    case (which)
      0:       btn_raw      = v;
      1:       joy_up_raw   = v;
      default: joy_down_raw = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_in(which, 1'b1);
    wait_neg(hold);
    set_in(which, 1'b0);
    wait_neg(N + 6);
  endtask

  initial begin
    wait_neg(2);
    chk("rst_enter", enter, 1'b0);
    chk("rst_value", value, 1'b0);
    chk("rst_sel", sel_changed, 1'b0);
    reset_n = 1'b1;
    wait_neg(3);

    // Button held 20 cycles: enter only after edge N+2.
    n_enter = 0;
    btn_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_neg(1);
      chk("enter_latency", enter, k == N + 2);
    end
    btn_raw = 1'b0;
    wait_neg(10);
    chk_int("enter_one_pulse", n_enter, 1);

    // Bounces of 3 cycles never qualify.
    n_enter = 0;
    repeat (5) begin
      btn_raw = 1'b1;
      wait_neg(3);
      btn_raw = 1'b0;
      wait_neg(3);
    end
    wait_neg(10);
    chk_int("glitch_enter", n_enter, 0);

    // Menu navigation.
    menu_active = 1'b1;
    n_sel = 0;
    press(2, 8);
    chk("down_value", value, 1'b1);
    press(2, 8);
    chk("down_again_value", value, 1'b1);
    chk_int("down_again_sel", n_sel, 1);
    press(1, 8);
    chk("up_value", value, 1'b0);
    chk_int("nav_sel_count", n_sel, 2);

    // Pulses outside the menu are dropped.
    menu_active = 1'b0;
    n_sel = 0;
    press(2, 8);
    chk("inactive_value", value, 1'b0);
    menu_active = 1'b1;
    wait_neg(5);
    chk("late_active_value", value, 1'b0);
    chk_int("inactive_sel", n_sel, 0);

    // Up and down together leave value alone.
    press(2, 8);
    chk("pre_both_value", value, 1'b1);
    n_sel = 0;
    joy_up_raw   = 1'b1;
    joy_down_raw = 1'b1;
    wait_neg(8);
    joy_up_raw   = 1'b0;
    joy_down_raw = 1'b0;
    wait_neg(10);
    chk("both_value", value, 1'b1);
    chk_int("both_sel", n_sel, 0);

    // clear_sel beats a down pulse in the same cycle.
    joy_down_raw = 1'b1;
    wait_neg(N + 2);
    clear_sel = 1'b1;
    wait_neg(1);
    clear_sel = 1'b0;
    chk("clear_value", value, 1'b0);
    chk("clear_sel_pulse", sel_changed, 1'b1);
    wait_neg(2);
    joy_down_raw = 1'b0;
    wait_neg(10);
    chk("clear_hold_value", value, 1'b0);

    // Reset mid-debounce, button still held after release.
    menu_active = 1'b0;
    n_enter = 0;
    btn_raw = 1'b1;
    wait_neg(4);
    reset_n = 1'b0;
    #1;
    chk("midrst_enter", enter, 1'b0);
    chk("midrst_value", value, 1'b0);
    wait_neg(1);
    chk("midrst_enter2", enter, 1'b0);
    reset_n = 1'b1;
    for (int k = 5; k < 15; k++) begin
      wait_neg(1);
      chk("post_rst_enter", enter, k == 11);
    end
    btn_raw = 1'b0;
    wait_neg(10);
    chk_int("post_rst_count", n_enter, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
